// File: rtl/clk_divs.sv
// Multi-channel clock-divider bank: runtime-loadable divisors, with divisor changes and
// enable/disable taking effect only at period boundaries so no runt pulses leave the block.
module clk_divs #(
  parameter int unsigned          NCH     = 2,
  parameter int unsigned          CW      = 8,
  parameter logic [NCH*CW-1:0]    DIV_RST = {8'd7, 8'd16}
) (
  input  logic           fclk,
  input  logic           rst,
  input  logic [NCH-1:0] ch_en,
  input  logic [NCH-1:0] div_ld,
  input  logic [CW-1:0]  div_val,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] clk_rise,
  output logic [NCH-1:0] running
);

  // Divisors below 2 cannot produce a high and a low phase, so they are raised to 2.
  logic [CW-1:0] ld_val;
  assign ld_val = (div_val < CW'(2)) ? CW'(2) : div_val;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic          run_q, run_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] div_q, div_d;
    logic [CW-1:0] pend_q, pend_d;
    logic          pv_q, pv_d;
    logic          out_q, out_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] half;
    logic [CW-1:0] cnt_inc;
    logic          at_end;

    assign half    = div_q >> 1;
    assign cnt_inc = cnt_q + CW'(1);
    assign at_end  = (cnt_q == div_q - CW'(1));

    always_comb begin
      run_d  = run_q;
      cnt_d  = cnt_q;
      div_d  = div_q;
      pend_d = pend_q;
      pv_d   = pv_q;
      out_d  = out_q;
      rise_d = 1'b0;
      if (!run_q) begin
        if (ch_en[i]) begin
          run_d  = 1'b1;
          cnt_d  = '0;
          out_d  = 1'b1;
          rise_d = 1'b1;
          if (pv_q) begin
            div_d = pend_q;
            pv_d  = 1'b0;
          end
        end else begin
          out_d = 1'b0;
        end
      end else if (!at_end) begin
        cnt_d = cnt_inc;
        out_d = (cnt_inc < half);
      end else if (!ch_en[i]) begin
        // Period finished while disabled: park low and keep any pending divisor.
        run_d = 1'b0;
        out_d = 1'b0;
      end else begin
        cnt_d  = '0;
        out_d  = 1'b1;
        rise_d = 1'b1;
        if (pv_q) begin
          div_d = pend_q;
          pv_d  = 1'b0;
        end
      end
      // A load on a boundary edge lands after adoption, so it waits for the next boundary.
      if (div_ld[i]) begin
        pend_d = ld_val;
        pv_d   = 1'b1;
      end
    end

    always_ff @(posedge fclk or posedge rst) begin
      if (rst) begin
        run_q  <= 1'b0;
        cnt_q  <= '0;
        div_q  <= DIV_RST[i*CW +: CW];
        pend_q <= DIV_RST[i*CW +: CW];
        pv_q   <= 1'b0;
        out_q  <= 1'b0;
        rise_q <= 1'b0;
      end else begin
        run_q  <= run_d;
        cnt_q  <= cnt_d;
        div_q  <= div_d;
        pend_q <= pend_d;
        pv_q   <= pv_d;
        out_q  <= out_d;
        rise_q <= rise_d;
      end
    end

    assign clk_out[i]  = out_q;
    assign clk_rise[i] = rise_q;
    assign running[i]  = run_q;
  end

endmodule

// File: tb/tb_clk_divs.sv
// Scoreboard bench for clk_divs: a default 2-channel bank and a 4-channel CW=4 bank are driven
// together and compared every cycle against a period-position model of each channel.
module tb_clk_divs;
  localparam int NT = 6;  // channels 0-1: bank A, 2-5: bank B

  logic       fclk = 1'b0;
  logic       rst  = 1'b1;
  logic [1:0] ch_en_a, div_ld_a, clk_out_a, clk_rise_a, running_a;
  logic [7:0] div_val_a;
  logic [3:0] ch_en_b, div_ld_b, clk_out_b, clk_rise_b, running_b;
  logic [3:0] div_val_b;

  clk_divs u_dut_a (
    .fclk     (fclk),
    .rst      (rst),
    .ch_en    (ch_en_a),
    .div_ld   (div_ld_a),
    .div_val  (div_val_a),
    .clk_out  (clk_out_a),
    .clk_rise (clk_rise_a),
    .running  (running_a)
  );

  clk_divs #(
    .NCH     (4),
    .CW      (4),
    .DIV_RST ({4'd7, 4'd6, 4'd5, 4'd4})
  ) u_dut_b (
    .fclk     (fclk),
    .rst      (rst),
    .ch_en    (ch_en_b),
    .div_ld   (div_ld_b),
    .div_val  (div_val_b),
    .clk_out  (clk_out_b),
    .clk_rise (clk_rise_b),
    .running  (running_b)
  );

  always #5 fclk = ~fclk;

  // Model: each running channel sits at position t within a period of length div;
  // the output is high for the first div/2 positions.
  int m_run [NT];
  int m_t   [NT];
  int m_div [NT];
  int m_pend[NT];
  int m_pv  [NT];
  int rst_div[NT] = '{16, 7, 4, 5, 6, 7};

  logic [NT-1:0]   en_r = '0;
  logic [NT-1:0]   ld_r = '0;
  logic            rst_r = 1'b1;
  int              va = 0;
  int              vb = 0;
  logic [3*NT-1:0] exp_q[$];
  int              checks = 0;
  int              errors = 0;

  function automatic logic [3*NT-1:0] dut_vec();
    return {running_b, running_a, clk_rise_b, clk_rise_a, clk_out_b, clk_out_a};
  endfunction

  function automatic logic [3*NT-1:0] model_vec();
    logic [NT-1:0] o, r, g;
    for (int c = 0; c < NT; c++) begin
      g[c] = (m_run[c] != 0);
      o[c] = g[c] && (m_t[c] < m_div[c] / 2);
      r[c] = g[c] && (m_t[c] == 0);
    end
    return {g, r, o};
  endfunction

  function automatic void model_step(input int c);
    int v;
    v = (c < 2) ? (va & 255) : (vb & 15);
    if (v < 2) v = 2;
    if (m_run[c] == 0) begin
      if (en_r[c]) begin
        m_run[c] = 1;
        m_t[c]   = 0;
        if (m_pv[c] != 0) begin
          m_div[c] = m_pend[c];
          m_pv[c]  = 0;
        end
      end
    end else if (m_t[c] == m_div[c] - 1) begin
      if (en_r[c]) begin
        m_t[c] = 0;
        if (m_pv[c] != 0) begin
          m_div[c] = m_pend[c];
          m_pv[c]  = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end else begin
      m_t[c] = m_t[c] + 1;
    end
    if (ld_r[c]) begin
      m_pend[c] = v;
      m_pv[c]   = 1;
    end
  endfunction

  task automatic tick();
    @(negedge fclk);
    rst       = rst_r;
    ch_en_a   = en_r[1:0];
    ch_en_b   = en_r[5:2];
    div_ld_a  = ld_r[1:0];
    div_ld_b  = ld_r[5:2];
    div_val_a = va[7:0];
    div_val_b = vb[3:0];
    if (rst_r) begin
      #1;
      checks++;
      if (dut_vec() != '0) begin
        errors++;
        $display("FAIL async_reset t=%0t got=%h want=0", $time, dut_vec());
      end
      for (int c = 0; c < NT; c++) begin
        m_run[c] = 0;
        m_t[c]   = 0;
        m_div[c] = rst_div[c];
        m_pv[c]  = 0;
      end
    end else begin
      for (int c = 0; c < NT; c++) model_step(c);
    end
    exp_q.push_back(model_vec());
    ld_r = '0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Advance until channel c will be at position tgt after the next edge (-1: last position).
  task automatic wait_pos(input int c, input int tgt, input string nm);
    int n;
    n = 0;
    while (m_run[c] == 0 || m_t[c] != ((tgt < 0) ? m_div[c] - 1 : tgt)) begin
      tick();
      n++;
      if (n > 64) begin
        checks++;
        errors++;
        $display("FAIL wait_%s ch=%0d got=timeout want=pos%0d", nm, c, tgt);
        return;
      end
    end
  endtask

  initial begin : monitor
    logic [3*NT-1:0] e;
    forever begin
      @(posedge fclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (dut_vec() !== e) begin
          errors++;
          $display("FAIL cycle t=%0t got=%h want=%h", $time, dut_vec(), e);
        end
      end
    end
  end

  initial begin : driver
    int idx;
    ch_en_a = '0; ch_en_b = '0; div_ld_a = '0; div_ld_b = '0;
    div_val_a = '0; div_val_b = '0;
    run(2);
    rst_r = 1'b0;
    // Bank B divisors 2, 3, 15, 16 (16 truncates to 0 and clamps to 2).
    for (int c = 0; c < 4; c++) begin
      ld_r[2 + c] = 1'b1;
      vb = (c == 0) ? 2 : (c == 1) ? 3 : (c == 2) ? 15 : 16;
      tick();
    end
    en_r = '1;
    run(40);
    wait_pos(0, 3, "load10");
    ld_r[0] = 1'b1; va = 10;
    tick();
    run(40);
    ld_r[1] = 1'b1; va = 5;
    tick();
    ld_r[1] = 1'b1; va = 0;
    tick();
    run(20);
    wait_pos(1, -1, "bound_ld");
    ld_r[1] = 1'b1; va = 9;
    tick();
    run(30);
    wait_pos(1, 1, "disable");
    en_r[1] = 1'b0;
    run(12);
    en_r[1] = 1'b1;
    run(10);
    wait_pos(0, 2, "midrst");
    rst_r = 1'b1;
    tick();
    rst_r = 1'b0;
    run(40);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        idx = $urandom_range(0, NT - 1);
        en_r[idx] = ~en_r[idx];
      end
      for (int c = 0; c < NT; c++) if ($urandom_range(0, 19) == 0) ld_r[c] = 1'b1;
      va = $urandom_range(0, 20);
      vb = $urandom_range(0, 17);
      rst_r = ($urandom_range(0, 599) == 0);
      tick();
      rst_r = 1'b0;
    end
    repeat (3) @(posedge fclk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
